// File: rtl/request_beat_serializer_if.sv
// Handshake bundle between the request FIFO, the beat serializer and the narrow downstream link.
// The slave view is the serializer; the master view drives it (FIFO side plus beat consumer).
interface request_beat_serializer_if #(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 32,
  parameter int unsigned BEAT_WIDTH_IN_BITS         = 8
);
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in;
  logic                                  request_valid_in;
  logic                                  issue_ack_out;
  logic [BEAT_WIDTH_IN_BITS-1:0]         beat_out;
  logic                                  beat_valid_out;
  logic                                  beat_last_out;
  logic                                  issue_ack_in;
  logic                                  is_busy_out;

  modport slave (
    input  request_in,
    input  request_valid_in,
    input  issue_ack_in,
    output issue_ack_out,
    output beat_out,
    output beat_valid_out,
    output beat_last_out,
    output is_busy_out
  );

  modport master (
    output request_in,
    output request_valid_in,
    output issue_ack_in,
    input  issue_ack_out,
    input  beat_out,
    input  beat_valid_out,
    input  beat_last_out,
    input  is_busy_out
  );
endinterface

// File: rtl/request_beat_serializer.sv
// Splits one wide FIFO entry into NUM_BEATS narrow beats, least-significant beat first.
// The entry is popped from the FIFO by a one-cycle issue_ack_out pulse at capture time.
module request_beat_serializer #(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 32,
  parameter int unsigned BEAT_WIDTH_IN_BITS         = 8,
  parameter int unsigned NUM_BEATS                  = 4,
  parameter int unsigned BEAT_CTR_WIDTH_IN_BITS     = 2
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  request_beat_serializer_if.slave bus_if
);

  localparam int unsigned EW = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int unsigned BW = BEAT_WIDTH_IN_BITS;
  localparam int unsigned CW = BEAT_CTR_WIDTH_IN_BITS;
  localparam logic [CW-1:0] LAST_BEAT   = CW'(NUM_BEATS - 1);
  localparam logic [CW-1:0] PENULT_BEAT = CW'(NUM_BEATS - 2);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e        state_q;
  logic [EW-1:0] shift_q;
  logic [EW-1:0] shift_d;
  logic [CW-1:0] ctr_q;
  logic [BW-1:0] beat_q;
  logic          ack_q;
  logic          valid_q;
  logic          last_q;
  logic          busy_q;
  logic          beat_taken;

  assign shift_d    = shift_q >> BW;
  assign beat_taken = bus_if.issue_ack_in & valid_q;

  // Capture in IDLE, then walk the shift register one beat per downstream ack.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      shift_q <= '0;
      ctr_q   <= '0;
      beat_q  <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_if.request_valid_in) begin
            shift_q <= bus_if.request_in;
            beat_q  <= bus_if.request_in[BW-1:0];
            ctr_q   <= '0;
            ack_q   <= 1'b1;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          // Stale request_valid_in during the ack cycle is deliberately ignored here.
          if (beat_taken) begin
            if (ctr_q == LAST_BEAT) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              ctr_q   <= ctr_q + CW'(1);
              shift_q <= shift_d;
              beat_q  <= shift_d[BW-1:0];
              last_q  <= (ctr_q == PENULT_BEAT);
            end
          end
        end
      endcase
    end
  end

  assign bus_if.issue_ack_out  = ack_q;
  assign bus_if.beat_out       = beat_q;
  assign bus_if.beat_valid_out = valid_q;
  assign bus_if.beat_last_out  = last_q;
  assign bus_if.is_busy_out    = busy_q;

endmodule

// File: doc/request_beat_serializer.md
Name: request_beat_serializer

Overview:
- Downstream stage of the request FIFO. Consumes whole entries from the FIFO's request_out/request_valid_out/issue_ack_in interface.
- Splits each entry into NUM_BEATS narrow beats and emits them, least-significant beat first, on a valid/ack interface of the same style, flagging the final beat.
- Used wherever a wide queued request must cross a narrower datapath (e.g. 32-bit entry onto an 8-bit link).

Parameters:
- SINGLE_ENTRY_WIDTH_IN_BITS, 32, width of one FIFO entry.
- BEAT_WIDTH_IN_BITS, 8, width of one output beat.
- NUM_BEATS, 4, beats per entry. Must equal SINGLE_ENTRY_WIDTH_IN_BITS / BEAT_WIDTH_IN_BITS and be at least 2.
- BEAT_CTR_WIDTH_IN_BITS, 2, beat counter width. Must satisfy 2^BEAT_CTR_WIDTH_IN_BITS >= NUM_BEATS.

Ports:
- clk_in  input  1  single clock, all state on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- request_in  input  SINGLE_ENTRY_WIDTH_IN_BITS  entry from FIFO.
- request_valid_in  input  1  entry valid, held by the FIFO until acked.
- issue_ack_out  output  1  registered one-cycle pulse: entry taken; the FIFO pops on the edge ending this cycle.
- beat_out  output  BEAT_WIDTH_IN_BITS  current beat.
- beat_valid_out  output  1  beat_out valid.
- beat_last_out  output  1  current beat is beat NUM_BEATS-1 of its entry.
- issue_ack_in  input  1  downstream accepts the current beat at this edge (one beat per high cycle).
- is_busy_out  output  1  high while an entry is held (state SEND).

Behaviour:
- Reset (async): state=IDLE; issue_ack_out=0, beat_valid_out=0, beat_last_out=0, beat_out=0, is_busy_out=0; beat counter=0; shift register=0.
- A reset mid-entry discards the remaining beats; nothing is replayed.
- States: IDLE, SEND.
- IDLE, rising edge with request_valid_in=1:
  - latch request_in into the shift register; beat_out <= request_in[BEAT_WIDTH_IN_BITS-1:0];
  - beat_valid_out <= 1; issue_ack_out <= 1; counter <= 0; state <= SEND.
  - Capture-to-first-beat latency is 1 cycle.
- IDLE, rising edge with request_valid_in=0: no change; issue_ack_out <= 0.
- SEND: issue_ack_out <= 0 on every edge, so the pulse is exactly one cycle wide. request_in/request_valid_in are ignored; stale valid during the ack cycle must not cause a second capture.
- SEND, edge with issue_ack_in=1 and counter < NUM_BEATS-1:
  - counter++; shift the register right by BEAT_WIDTH_IN_BITS (zero fill); beat_out <= next beat;
  - beat_valid_out stays 1, so back-to-back acks give one beat per cycle.
- SEND, edge with issue_ack_in=1 and counter == NUM_BEATS-1: beat_valid_out <= 0, beat_last_out <= 0, state <= IDLE.
- SEND, edge with issue_ack_in=0: hold beat_out, beat_valid_out, beat_last_out and counter unchanged (stall of any length).
- beat_last_out: registered; equals beat_valid_out AND (counter == NUM_BEATS-1).
- is_busy_out = (state == SEND).
- issue_ack_in while beat_valid_out=0 is ignored.
- Throughput: with issue_ack_in tied high, one entry per NUM_BEATS+1 cycles. There is one idle bubble between entries; this is intentional, since the capture edge must follow the ack pulse.
- No partial entries; width mismatch between parameters is a configuration error and is not checked in RTL.

Test Plan:
- Reset then request_in=0x12345678 valid, issue_ack_in held 1 -> issue_ack_out high exactly 1 cycle; beats 0x78,0x56,0x34,0x12 on 4 consecutive cycles; beat_last_out only with 0x12; beat_valid_out low the next cycle.
- Same entry, issue_ack_in pulsed every 16 cycles (clk_ctr[3:0]==0) -> each beat held stable until acked, order and last flag unchanged, no extra issue_ack_out.
- Connected to fifo_queue, producer decrementing from 0xFFFFFFFF -> beat stream reads FF,FF,FF,FF, FE,FF,FF,FF, FD,FF,FF,FF...; no entry lost or duplicated; FIFO is_full never causes corruption.
- request_valid_in held 1 continuously with a constant value during SEND -> exactly one issue_ack_out per NUM_BEATS beats; no capture while is_busy_out=1.
- Assert reset_in after the 2nd beat of 0xAABBCCDD -> all outputs 0 immediately (asynchronous); after release the next captured entry starts at beat 0 with its own low byte.
- issue_ack_in=1 while IDLE with request_valid_in=0 -> no state change, beat_valid_out stays 0.
